// File: rtl/serial_tx_arbiter.sv
// ----------------------------------------------------------------------------
// serial_tx_arbiter
//   Shares one byte-wide serial transmit path between NREQ packet sources.
//   A requester is granted for a whole packet (round-robin, one grant per
//   packet), so packet bytes are never interleaved. A grant ends on the byte
//   flagged req_last, or after MAXLEN bytes, whichever comes first. In the
//   second case the packet is cut and its remainder is arbitrated again.
//   GAP idle clocks follow every packet so the far end can resynchronise on
//   line silence.
//
// Ports
//   clk        in   system clock
//   rst        in   synchronous reset, active high
//   req_valid  in   [NREQ]    requester i presents a byte
//   req_data   in   [8*NREQ]  byte of requester i at [8i+7:8i]
//   req_last   in   [NREQ]    presented byte ends requester i's packet
//   req_ready  out  [NREQ]    byte of requester i taken this clock (comb.)
//   tx_ready   in   downstream FIFO can take a byte
//   xmit       out  one-clock write strobe, one clock after the accept
//   txchar     out  byte qualified by xmit
//   grant_id   out  current / last grantee
//   busy       out  arbiter not idle
//   trunc      out  one-clock pulse with the byte that hit MAXLEN w/o last
// ----------------------------------------------------------------------------
module serial_tx_arbiter #(
  parameter int NREQ   = 4,
  parameter int MAXLEN = 16,
  parameter int GAP    = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NREQ-1:0]           req_valid,
  input  logic [8*NREQ-1:0]         req_data,
  input  logic [NREQ-1:0]           req_last,
  output logic [NREQ-1:0]           req_ready,
  input  logic                      tx_ready,
  output logic                      xmit,
  output logic [7:0]                txchar,
  output logic [$clog2(NREQ)-1:0]   grant_id,
  output logic                      busy,
  output logic                      trunc
);

  localparam int IW = $clog2(NREQ);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARB,
    ST_XFER,
    ST_GAP
  } state_t;

  state_t        state_q;
  logic [IW-1:0] grant_q;
  logic [IW-1:0] ptr_q;
  logic [7:0]    ctr_q;
  logic [7:0]    gap_q;
  logic          xmit_q;
  logic [7:0]    txchar_q;
  logic          busy_q;
  logic          trunc_q;

  // Round-robin search starting at ptr_q. ptr_q always points one past the
  // last served requester, so that requester has the lowest priority.
  logic [IW-1:0] arb_sel;
  logic          arb_found;
  int            idx;

  always_comb begin
    arb_sel   = '0;
    arb_found = 1'b0;
    idx       = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(ptr_q) + k) % NREQ;
      if (!arb_found && req_valid[idx]) begin
        arb_found = 1'b1;
        arb_sel   = IW'(idx);
      end
    end
  end

  // Only the grantee can see ready, and only while in XFER with room downstream.
  for (genvar gi = 0; gi < NREQ; gi++) begin : g_ready
    assign req_ready[gi] = (state_q == ST_XFER) && (grant_q == IW'(gi)) &&
                           req_valid[gi] && tx_ready;
  end

  logic          accept;
  logic          cur_last;
  logic [7:0]    cur_byte;
  logic [IW-1:0] ptr_nxt;

  assign accept   = |req_ready;
  assign cur_last = req_last[grant_q];
  assign cur_byte = req_data[{grant_q, 3'b000} +: 8];
  assign ptr_nxt  = (grant_q == IW'(NREQ - 1)) ? '0 : grant_q + IW'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      grant_q  <= '0;
      ptr_q    <= '0;
      ctr_q    <= '0;
      gap_q    <= '0;
      xmit_q   <= 1'b0;
      txchar_q <= '0;
      busy_q   <= 1'b0;
      trunc_q  <= 1'b0;
    end else begin
      // Strobes are single-clock by default.
      xmit_q  <= 1'b0;
      trunc_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (|req_valid) begin
            state_q <= ST_ARB;
            busy_q  <= 1'b1;
          end
        end
        ST_ARB: begin
          if (arb_found) begin
            grant_q <= arb_sel;
            ctr_q   <= '0;
            state_q <= ST_XFER;
          end else begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        end
        ST_XFER: begin
          // Stalls (no valid or no tx_ready) simply wait: the grantee owns
          // the link until its packet ends.
          if (accept) begin
            xmit_q   <= 1'b1;
            txchar_q <= cur_byte;
            ctr_q    <= ctr_q + 8'd1;
            if (cur_last || ctr_q == 8'(MAXLEN - 1)) begin
              // A last byte landing exactly on the MAXLEN boundary is a
              // normal end, hence trunc only when last is absent.
              trunc_q <= !cur_last;
              ptr_q   <= ptr_nxt;
              gap_q   <= '0;
              state_q <= (GAP == 0) ? ST_ARB : ST_GAP;
            end
          end
        end
        ST_GAP: begin
          if (gap_q == 8'(GAP - 1)) begin
            if (|req_valid) begin
              state_q <= ST_ARB;
            end else begin
              state_q <= ST_IDLE;
              busy_q  <= 1'b0;
            end
          end else begin
            gap_q <= gap_q + 8'd1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign xmit     = xmit_q;
  assign txchar   = txchar_q;
  assign grant_id = grant_q;
  assign busy     = busy_q;
  assign trunc    = trunc_q;

endmodule

// File: tb/tb_serial_tx_arbiter.sv
// ----------------------------------------------------------------------------
// tb_serial_tx_arbiter
//   Drives packet queues per requester and checks every byte, grant, gap and
//   truncation against a queue-based reference of the arbitration rules.
//   A second instance built with GAP=0 covers the back-to-back case.
// ----------------------------------------------------------------------------
module tb_serial_tx_arbiter;

  localparam int NREQ   = 4;
  localparam int MAXLEN = 16;
  localparam int GAP    = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #10 clk = ~clk;

  // main instance (GAP=8)
  logic [NREQ-1:0]   req_valid = '0;
  logic [NREQ-1:0]   req_last  = '0;
  logic [8*NREQ-1:0] req_data  = '0;
  logic              tx_ready  = 1'b0;
  logic [NREQ-1:0]   req_ready;
  logic              xmit, busy, trunc;
  logic [7:0]        txchar;
  logic [1:0]        grant_id;

  // GAP=0 instance
  logic [NREQ-1:0]   z_req_valid = '0;
  logic [NREQ-1:0]   z_req_last  = '0;
  logic [8*NREQ-1:0] z_req_data  = '0;
  logic              z_tx_ready  = 1'b0;
  logic [NREQ-1:0]   z_req_ready;
  logic              z_xmit, z_busy, z_trunc;
  logic [7:0]        z_txchar;
  logic [1:0]        z_grant_id;

  serial_tx_arbiter #(.NREQ(NREQ), .MAXLEN(MAXLEN), .GAP(GAP)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .tx_ready(tx_ready),
    .xmit(xmit), .txchar(txchar), .grant_id(grant_id), .busy(busy), .trunc(trunc)
  );

  serial_tx_arbiter #(.NREQ(NREQ), .MAXLEN(MAXLEN), .GAP(0)) dut_g0 (
    .clk(clk), .rst(rst), .req_valid(z_req_valid), .req_data(z_req_data),
    .req_last(z_req_last), .req_ready(z_req_ready), .tx_ready(z_tx_ready),
    .xmit(z_xmit), .txchar(z_txchar), .grant_id(z_grant_id), .busy(z_busy),
    .trunc(z_trunc)
  );

  int checks = 0;
  int errors = 0;
  int cur    = 0;          // 0: main instance, 1: GAP=0 instance

  // requester byte queues (head/tail indices)
  logic [7:0] mem_d [NREQ][1024];
  bit         mem_l [NREQ][1024];
  int         hd [NREQ];
  int         tl [NREQ];

  // reference state
  int   cyc = 0;
  bit   in_seg, had_end, exp_pend, exp_trunc;
  int   seg_g, seg_len, rr, end_cyc, exp_gid, n_trunc, n_acc, first_acc_cyc, busy_fall_cyc;
  logic [7:0] exp_byte;
  logic last_busy = 1'b0;
  int   seg_log_g[$];
  int   seg_log_len[$];
  int   xmit_cycs[$];
  int   txr_pct = 100;
  int   bubble_pct = 0;
  bit   txr_low = 0;

  function automatic bit all_empty();
    bit e = 1'b1;
    for (int i = 0; i < NREQ; i++) if (hd[i] < tl[i]) e = 1'b0;
    return e;
  endfunction

  task automatic clear_logs();
    seg_log_g.delete();
    seg_log_len.delete();
    xmit_cycs.delete();
    n_trunc = 0; n_acc = 0; first_acc_cyc = -1; busy_fall_cyc = -1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < NREQ; i++) begin hd[i] = 0; tl[i] = 0; end
    in_seg = 0; had_end = 0; exp_pend = 0; exp_trunc = 0; rr = 0;
    seg_g = 0; seg_len = 0; end_cyc = 0; exp_gid = 0; exp_byte = 8'h00;
    last_busy = 1'b0;
    clear_logs();
  endtask

  task automatic push_byte(input int r, input logic [7:0] b, input bit last);
    mem_d[r][tl[r]] = b;
    mem_l[r][tl[r]] = last;
    tl[r]++;
  endtask

  task automatic push_pkt(input int r, input int len);
    for (int k = 0; k < len; k++) push_byte(r, 8'($urandom), k == len - 1);
  endtask

  // Present queue heads; the current grantee may randomly bubble mid-packet.
  task automatic drive();
    logic [NREQ-1:0]   v, l;
    logic [8*NREQ-1:0] d;
    logic              t;
    v = '0; l = '0; d = '0;
    for (int i = 0; i < NREQ; i++) begin
      d[8*i +: 8] = 8'($urandom);
      if (!rst && hd[i] < tl[i]) begin
        if (!(in_seg && i == seg_g && $urandom_range(99) < bubble_pct)) begin
          v[i] = 1'b1;
          d[8*i +: 8] = mem_d[i][hd[i]];
          l[i] = mem_l[i][hd[i]];
        end
      end
    end
    t = !txr_low && ($urandom_range(99) < txr_pct);
    if (cur == 0) begin
      req_valid = v; req_data = d; req_last = l; tx_ready = t;
      z_req_valid = '0; z_req_last = '0; z_tx_ready = 1'b0;
    end else begin
      z_req_valid = v; z_req_data = d; z_req_last = l; z_tx_ready = t;
      req_valid = '0; req_last = '0; tx_ready = 1'b0;
    end
  endtask

  // One clock: sample at negedge, score, then drive after the posedge.
  task automatic step();
    logic [NREQ-1:0] rdy;
    logic xm, tr, bz, txr, vld;
    logic [7:0] tc;
    int gid, i, expg, gapv;
    bit lst, endp;
    @(negedge clk);
    cyc++;
    if (cur == 0) begin
      rdy = req_ready; xm = xmit; tr = trunc; bz = busy; tc = txchar; gid = int'(grant_id);
      txr = tx_ready; gapv = GAP;
    end else begin
      rdy = z_req_ready; xm = z_xmit; tr = z_trunc; bz = z_busy; tc = z_txchar;
      gid = int'(z_grant_id); txr = z_tx_ready; gapv = 0;
    end
    if (last_busy === 1'b1 && bz === 1'b0) busy_fall_cyc = cyc;
    last_busy = bz;
    checks++;
    if (exp_pend) begin
      if (xm !== 1'b1 || tc !== exp_byte || gid != exp_gid || tr !== exp_trunc) begin
        errors++;
        $display("FAIL xmit_byte cyc %0d: got xmit=%b txchar=%h grant_id=%0d trunc=%b, expected xmit=1 txchar=%h grant_id=%0d trunc=%b",
                 cyc, xm, tc, gid, tr, exp_byte, exp_gid, exp_trunc);
      end
      xmit_cycs.push_back(cyc);
    end else if (xm !== 1'b0 || tr !== 1'b0) begin
      errors++;
      $display("FAIL idle_strobe cyc %0d: got xmit=%b trunc=%b, expected 0 0", cyc, xm, tr);
    end
    exp_pend = 0;
    if (rdy !== '0) begin
      i = 0;
      for (int k = 0; k < NREQ; k++) if (rdy[k] === 1'b1) i = k;
      vld = (cur == 0) ? req_valid[i] : z_req_valid[i];
      checks++;
      if ($countones(rdy) != 1 || hd[i] >= tl[i] || txr !== 1'b1 || vld !== 1'b1) begin
        errors++;
        $display("FAIL bad_ready cyc %0d: got req_ready=%b tx_ready=%b, expected one-hot ready on a valid requester with tx_ready=1",
                 cyc, rdy, txr);
      end else begin
        if (!in_seg) begin
          expg = -1;
          for (int k = 0; k < NREQ; k++) begin
            int r;
            r = (rr + k) % NREQ;
            if (expg < 0 && hd[r] < tl[r]) expg = r;
          end
          checks++;
          if (i != expg) begin
            errors++;
            $display("FAIL rr_grant cyc %0d: got grantee %0d, expected %0d", cyc, i, expg);
          end
          if (had_end) begin
            checks++;
            if (cyc - end_cyc < gapv + 2) begin
              errors++;
              $display("FAIL gap cyc %0d: got %0d clks between packet accepts, expected >= %0d",
                       cyc, cyc - end_cyc, gapv + 2);
            end
          end
          in_seg = 1; seg_g = i; seg_len = 0;
          if (first_acc_cyc < 0) first_acc_cyc = cyc;
          seg_log_g.push_back(i);
        end else begin
          checks++;
          if (i != seg_g) begin
            errors++;
            $display("FAIL interleave cyc %0d: got requester %0d, expected %0d", cyc, i, seg_g);
          end
        end
        lst       = mem_l[i][hd[i]];
        exp_pend  = 1;
        exp_byte  = mem_d[i][hd[i]];
        exp_gid   = i;
        hd[i]++;
        seg_len++;
        n_acc++;
        endp      = lst || seg_len == MAXLEN;
        exp_trunc = endp && !lst;
        if (exp_trunc) n_trunc++;
        if (endp) begin
          $display("packet req=%0d len=%0d cut=%0b end_cyc=%0d", i, seg_len, exp_trunc, cyc);
          in_seg = 0; rr = (i + 1) % NREQ; end_cyc = cyc; had_end = 1;
          seg_log_len.push_back(seg_len);
        end
      end
    end
    @(posedge clk);
    #1;
    drive();
  endtask

  task automatic run_idle(input int budget, input string name);
    int n = 0;
    while (n < budget && !(all_empty() && !in_seg && !exp_pend && last_busy === 1'b0)) begin
      step();
      n++;
    end
    checks++;
    if (n >= budget) begin
      errors++;
      $display("FAIL timeout_%s: got %0d clks without draining, expected < %0d", name, n, budget);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive();
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    rst = 1'b0;
    txr_pct = 100; bubble_pct = 0; txr_low = 0;
    drive();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_valid = '1; tx_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks += 6;
    if (xmit !== 1'b0)     begin errors++; $display("FAIL reset_xmit: got %b, expected 0", xmit); end
    if (txchar !== 8'h00)  begin errors++; $display("FAIL reset_txchar: got %h, expected 00", txchar); end
    if (grant_id !== 2'd0) begin errors++; $display("FAIL reset_grant: got %0d, expected 0", grant_id); end
    if (busy !== 1'b0)     begin errors++; $display("FAIL reset_busy: got %b, expected 0", busy); end
    if (trunc !== 1'b0)    begin errors++; $display("FAIL reset_trunc: got %b, expected 0", trunc); end
    if (req_ready !== '0)  begin errors++; $display("FAIL reset_ready: got %b, expected 0", req_ready); end
    @(posedge clk);
    #1;
    do_reset();
  endtask

  task automatic test_single();
    int pcyc;
    do_reset();
    push_byte(0, 8'hA1, 0); push_byte(0, 8'hB2, 0); push_byte(0, 8'hC3, 1);
    pcyc = cyc;
    drive();
    run_idle(200, "single");
    checks += 4;
    if (xmit_cycs.size() != 3) begin
      errors++; $display("FAIL single_count: got %0d xmits, expected 3", xmit_cycs.size());
    end else begin
      if (xmit_cycs[2] - xmit_cycs[0] != 2) begin
        errors++; $display("FAIL single_consec: got span %0d, expected 2", xmit_cycs[2] - xmit_cycs[0]);
      end
      if (busy_fall_cyc - xmit_cycs[2] != GAP) begin
        errors++; $display("FAIL single_gap: got busy fall %0d clks after last xmit, expected %0d",
                           busy_fall_cyc - xmit_cycs[2], GAP);
      end
    end
    if (first_acc_cyc != pcyc + 3) begin
      errors++; $display("FAIL single_latency: got first accept at %0d, expected %0d", first_acc_cyc, pcyc + 3);
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    push_pkt(0, 3); push_pkt(2, 2);
    drive();
    run_idle(300, "simul1");
    checks++;
    if (seg_log_g.size() != 2 || seg_log_g[0] != 0 || seg_log_g[1] != 2) begin
      errors++; $display("FAIL simul_order1: got %p, expected '{0,2}", seg_log_g);
    end
    clear_logs();
    push_pkt(2, 2); push_pkt(1, 2);
    drive();
    run_idle(300, "simul2");
    checks++;
    if (seg_log_g.size() != 2 || seg_log_g[0] != 1 || seg_log_g[1] != 2) begin
      errors++; $display("FAIL simul_order2: got %p, expected '{1,2}", seg_log_g);
    end
  endtask

  task automatic test_maxlen();
    do_reset();
    push_pkt(1, 20);
    drive();
    run_idle(400, "maxlen");
    checks += 3;
    if (seg_log_len.size() != 2 || seg_log_len[0] != 16 || seg_log_len[1] != 4) begin
      errors++; $display("FAIL maxlen_split: got %p, expected '{16,4}", seg_log_len);
    end
    if (n_trunc != 1) begin errors++; $display("FAIL maxlen_trunc: got %0d cuts, expected 1", n_trunc); end
    if (xmit_cycs.size() != 20) begin
      errors++; $display("FAIL maxlen_bytes: got %0d xmits, expected 20", xmit_cycs.size());
    end
  endtask

  task automatic test_tx_stall();
    int n, acc0;
    do_reset();
    push_pkt(3, 6);
    drive();
    n = 0;
    while (n_acc < 2 && n < 50) begin step(); n++; end
    checks++;
    if (n >= 50) begin errors++; $display("FAIL stall_start: got %0d accepts, expected 2", n_acc); end
    txr_low = 1;
    drive();
    acc0 = n_acc;
    repeat (5) step();
    checks++;
    if (n_acc != acc0) begin
      errors++; $display("FAIL stall_accept: got %0d accepts while tx_ready low, expected 0", n_acc - acc0);
    end
    txr_low = 0;
    drive();
    run_idle(200, "stall");
    checks++;
    if (xmit_cycs.size() != 6) begin
      errors++; $display("FAIL stall_bytes: got %0d xmits, expected 6", xmit_cycs.size());
    end
  endtask

  task automatic test_reset_mid();
    int n;
    do_reset();
    push_pkt(2, 1);
    drive();
    run_idle(100, "rst_pre");
    push_pkt(2, 5);
    drive();
    n = 0;
    while (n_acc < 3 && n < 60) begin step(); n++; end
    checks++;
    if (n >= 60) begin errors++; $display("FAIL rst_mid_start: got %0d accepts, expected 3", n_acc); end
    rst = 1'b1;
    drive();
    step();
    @(negedge clk);
    checks += 3;
    if (xmit !== 1'b0)     begin errors++; $display("FAIL rst_mid_xmit: got %b, expected 0", xmit); end
    if (busy !== 1'b0)     begin errors++; $display("FAIL rst_mid_busy: got %b, expected 0", busy); end
    if (grant_id !== 2'd0) begin errors++; $display("FAIL rst_mid_grant: got %0d, expected 0", grant_id); end
    @(posedge clk);
    #1;
    model_reset();
    rst = 1'b0;
    push_pkt(3, 2); push_pkt(0, 2);
    drive();
    run_idle(200, "rst_post");
    checks++;
    if (seg_log_g.size() != 2 || seg_log_g[0] != 0 || seg_log_g[1] != 3) begin
      errors++; $display("FAIL rst_mid_order: got %p, expected '{0,3}", seg_log_g);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    cur = 1;
    push_pkt(0, 3); push_pkt(1, 3);
    drive();
    run_idle(200, "gap0");
    checks += 2;
    if (xmit_cycs.size() != 6 || xmit_cycs[3] - xmit_cycs[2] != 2) begin
      errors++; $display("FAIL gap0_spacing: got %0d xmits at %p, expected 6 with one free clk between packets",
                         xmit_cycs.size(), xmit_cycs);
    end
    if (seg_log_g.size() != 2 || seg_log_g[0] != 0 || seg_log_g[1] != 1) begin
      errors++; $display("FAIL gap0_order: got %p, expected '{0,1}", seg_log_g);
    end
    cur = 0;
    drive();
  endtask

  task automatic test_random();
    do_reset();
    for (int round = 0; round < 6; round++) begin
      txr_pct    = $urandom_range(100, 40);
      bubble_pct = $urandom_range(30, 0);
      for (int r = 0; r < NREQ; r++) begin
        int np;
        np = $urandom_range(3, 0);
        for (int p = 0; p < np; p++) push_pkt(r, $urandom_range(24, 1));
      end
      push_pkt($urandom_range(NREQ - 1, 0), $urandom_range(24, 1));
      drive();
      run_idle(6000, "random");
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single();
    test_simultaneous();
    test_maxlen();
    test_tx_stall();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
